// File: rtl/phase_sequencer_pkg.sv
// Shared encodings for the traffic-light phase sequencer.
package phase_sequencer_pkg;

    localparam int unsigned TW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        RED    = 2'd3
    } state_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    // Lamp pattern shown in a given state; IDLE shows red.
    function automatic logic [2:0] lights_of(input state_t s);
        case (s)
            GREEN:   lights_of = LIGHT_GREEN;
            YELLOW:  lights_of = LIGHT_YELLOW;
            default: lights_of = LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_sequencer_countdown_timer.sv
// Loadable down counter holding the ticks left in the current phase.
module countdown_timer
    import phase_sequencer_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic [TW-1:0] load_value,
    input  logic          dec,
    output logic [TW-1:0] count,
    output logic          is_one
);

    logic [TW-1:0] count_next;

    // Load wins over decrement.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_value;
        end else if (dec) begin
            count_next = count - TW'(1);
        end
    end

    // is_one is registered alongside the count so it always matches it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            is_one <= 1'b0;
        end else begin
            count  <= count_next;
            is_one <= (count_next == TW'(1));
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Traffic-light phase controller: GREEN -> YELLOW -> RED with pedestrian shortening.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned T_GREEN     = 9,
    parameter int unsigned T_YELLOW    = 2,
    parameter int unsigned T_RED       = 7,
    parameter int unsigned SHORT_GREEN = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          tick,
    input  logic          ped_button,
    output logic [2:0]    lights,
    output logic          walk,
    output logic          ped_pending,
    output logic [TW-1:0] remaining,
    output logic          phase_done
);

    // Durations must fit the timer and be non-zero, otherwise a phase would never end.
    if (T_GREEN == 0 || T_GREEN > 15 || T_YELLOW == 0 || T_YELLOW > 15 ||
        T_RED == 0 || T_RED > 15 || SHORT_GREEN == 0 || SHORT_GREEN > 15) begin : g_bad_duration
        $error("phase_sequencer: phase durations must be in 1..15");
    end

    localparam logic [TW-1:0] D_GREEN  = TW'(T_GREEN);
    localparam logic [TW-1:0] D_YELLOW = TW'(T_YELLOW);
    localparam logic [TW-1:0] D_RED    = TW'(T_RED);
    localparam logic [TW-1:0] D_SHORT  = TW'(SHORT_GREEN);

    state_t        state;
    state_t        state_next;
    state_t        phase_after;
    logic [TW-1:0] dur_after;
    logic          ld;
    logic [TW-1:0] ld_val;
    logic          dec;
    logic          done_next;
    logic          ped_set;
    logic          ped_clr;
    logic          timer_is_one;

    // Successor phase and its duration.
    always_comb begin
        phase_after = GREEN;
        dur_after   = D_GREEN;
        case (state)
            GREEN: begin
                phase_after = YELLOW;
                dur_after   = D_YELLOW;
            end
            YELLOW: begin
                phase_after = RED;
                dur_after   = D_RED;
            end
            default: begin
                phase_after = GREEN;
                dur_after   = D_GREEN;
            end
        endcase
    end

    // Next state and timer control, in priority order stop > expiry > shorten > count.
    always_comb begin
        state_next = state;
        ld         = 1'b0;
        ld_val     = '0;
        dec        = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = GREEN;
                    ld         = 1'b1;
                    ld_val     = D_GREEN;
                end
            end
            default: begin
                if (!enable) begin
                    state_next = IDLE;
                    ld         = 1'b1;
                    ld_val     = '0;
                end else if (tick && timer_is_one) begin
                    state_next = phase_after;
                    ld         = 1'b1;
                    ld_val     = dur_after;
                    done_next  = 1'b1;
                end else if (state == GREEN && (ped_pending || ped_button) &&
                             remaining > D_SHORT) begin
                    ld         = 1'b1;
                    ld_val     = D_SHORT;
                end else if (tick) begin
                    dec        = 1'b1;
                end
            end
        endcase
    end

    // Request latch: armed during GREEN/YELLOW, dropped on entering RED or IDLE.
    always_comb begin
        ped_set = ped_button && (state == GREEN || state == YELLOW);
        ped_clr = (state_next == IDLE) || (state_next == RED && state != RED);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            lights      <= LIGHT_RED;
            walk        <= 1'b0;
            ped_pending <= 1'b0;
            phase_done  <= 1'b0;
        end else begin
            state      <= state_next;
            lights     <= lights_of(state_next);
            walk       <= (state_next == RED);
            phase_done <= done_next;
            if (ped_clr) begin
                ped_pending <= 1'b0;
            end else if (ped_set) begin
                ped_pending <= 1'b1;
            end
        end
    end

    countdown_timer u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (ld),
        .load_value (ld_val),
        .dec        (dec),
        .count      (remaining),
        .is_one     (timer_is_one)
    );

endmodule
